adc_serial_if: RTL and testbench

//  Upstream ADC front end of the acquisition system. On a start-conversion request (SC) from the

---
 rtl/adc_serial_if.sv | 152 +++++++++++++++
 tb/tb_adc_serial_if.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_if.sv
// Serial ADC front end. It handles one conversion per start request: chip-select and a
// conversion wait, then DATA_W bits clocked MSB-first. The result goes out on data_out with a
// one-cycle eoc strobe. Every output is registered.
module adc_serial_if #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned CONV_CYCLES = 12,
    parameter int unsigned SCLK_DIV    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sc,
    input  logic              adc_sdo,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] data_out,
    output logic              eoc,
    output logic              busy,
    output logic              ovr
);

    localparam int unsigned CONV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int unsigned DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned BIT_W  = $clog2(DATA_W);

    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StConv, StShift, StDone} state_e;

    state_e              state_q, state_d;
    logic                sc_q;
    logic                start;
    logic [CONV_W-1:0]   conv_cnt_q;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   data_q;
    logic                ovr_q;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                eoc_q, eoc_d;
    logic                busy_q, busy_d;
    logic                phase_end;
    logic                sample;
    logic                last_bit;

    assign start     = sc & ~sc_q;
    // The current SCLK half-period ends on this edge.
    assign phase_end = (state_q == StShift) && (div_cnt_q == DIV_LAST);
    // The edge that drives sclk 0->1 is the one that captures adc_sdo.
    assign sample    = phase_end && !sclk_q;
    assign last_bit  = (bit_cnt_q == BIT_LAST);

    // State register and sc edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc;
        end
    end

    // Next-state sequencing. A start seen in any state other than idle changes nothing here.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StConv;
            StConv:  if (conv_cnt_q == CONV_LAST) state_d = StShift;
            StShift: if (phase_end && sclk_q && last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the output registers, derived from the state being entered.
    always_comb begin
        cs_n_d = !((state_d == StConv) || (state_d == StShift));
        sclk_d = (state_d == StShift) ? (sclk_q ^ phase_end) : 1'b0;
        eoc_d  = (state_d == StDone);
        busy_d = (state_d != StIdle);
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n_q <= 1'b1;
            sclk_q <= 1'b0;
            eoc_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            cs_n_q <= cs_n_d;
            sclk_q <= sclk_d;
            eoc_q  <= eoc_d;
            busy_q <= busy_d;
        end
    end

    // Counters, the shift register, the result register and the sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_cnt_q <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            ovr_q      <= 1'b0;
        end else begin
            conv_cnt_q <= (state_q == StConv) ? conv_cnt_q + 1'b1 : '0;

            if (state_q != StShift) begin
                div_cnt_q <= '0;
            end else if (div_cnt_q == DIV_LAST) begin
                div_cnt_q <= '0;
            end else begin
                div_cnt_q <= div_cnt_q + 1'b1;
            end

            // Advance once per full SCLK period, at the end of its high phase.
            if (state_q != StShift) begin
                bit_cnt_q <= '0;
            end else if (phase_end && sclk_q) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end

            if (start && (state_q == StIdle)) begin
                shift_q <= '0;
            end else if (sample) begin
                shift_q <= {shift_q[DATA_W-2:0], adc_sdo};
            end

            if (state_d == StDone) begin
                data_q <= shift_q;
            end

            // An accepted start clears the flag. A start while busy sets it.
            if (start) begin
                ovr_q <= (state_q != StIdle);
            end
        end
    end

    assign adc_cs_n = cs_n_q;
    assign adc_sclk = sclk_q;
    assign data_out = data_q;
    assign eoc      = eoc_q;
    assign busy     = busy_q;
    assign ovr      = ovr_q;

endmodule

// File: tb/tb_adc_serial_if.sv
// Directed bench for adc_serial_if. It uses a default instance and a second instance with
// SCLK_DIV=3, CONV_CYCLES=1. Each instance has a small behavioural ADC that serves a word
// MSB-first.
module tb_adc_serial_if;

    logic        clk = 1'b0;
    logic        rst, sc, adc_sdo, adc_cs_n, adc_sclk, eoc, busy, ovr;
    logic [31:0] data_out;
    logic        rst2, sc2, adc_sdo2, adc_cs2_n, adc_sclk2, eoc2, busy2, ovr2;
    logic [31:0] data_out2;

    always #5 clk = ~clk;

    adc_serial_if dut (
        .clk(clk), .rst(rst), .sc(sc), .adc_sdo(adc_sdo), .adc_cs_n(adc_cs_n),
        .adc_sclk(adc_sclk), .data_out(data_out), .eoc(eoc), .busy(busy), .ovr(ovr)
    );

    adc_serial_if #(.DATA_W(32), .CONV_CYCLES(1), .SCLK_DIV(3)) dut2 (
        .clk(clk), .rst(rst2), .sc(sc2), .adc_sdo(adc_sdo2), .adc_cs_n(adc_cs2_n),
        .adc_sclk(adc_sclk2), .data_out(data_out2), .eoc(eoc2), .busy(busy2), .ovr(ovr2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ADC models: on each falling clk edge, present the bit the next sclk rise will capture.
    logic [31:0] adc_word, adc_word2;
    int          idx1 = 0, idx2 = 0;
    logic        prev1 = 1'b0, prev2 = 1'b0;

    always @(negedge clk) begin
        if (adc_cs_n !== 1'b0) idx1 = 0;
        else if (adc_sclk && !prev1) idx1++;
        prev1   = adc_sclk;
        adc_sdo = (idx1 < 32) ? adc_word[31-idx1] : 1'b0;
    end

    always @(negedge clk) begin
        if (adc_cs2_n !== 1'b0) idx2 = 0;
        else if (adc_sclk2 && !prev2) idx2++;
        prev2    = adc_sclk2;
        adc_sdo2 = (idx2 < 32) ? adc_word2[31-idx2] : 1'b0;
    end

    int eoc_cnt = 0, eoc_cnt2 = 0, sclk_cnt = 0, sclk_cnt2 = 0;
    always @(posedge clk) if (eoc === 1'b1) eoc_cnt++;
    always @(posedge clk) if (eoc2 === 1'b1) eoc_cnt2++;
    always @(posedge adc_sclk) sclk_cnt++;
    always @(posedge adc_sclk2) sclk_cnt2++;

    // One conversion: sc rises just after edge 0 and is held for one cycle. lat is the edge
    // after which eoc was first seen high, or -1 on timeout.
    task automatic run_conv(input bit sel, input logic [31:0] w, output int lat,
                            output logic [31:0] d, output int cs_low, output int nsclk);
        lat    = -1;
        d      = '0;
        cs_low = 0;
        if (sel) begin adc_word2 = w; sclk_cnt2 = 0; end
        else begin adc_word = w; sclk_cnt = 0; end
        @(posedge clk); #1;
        if (sel) sc2 = 1'b1; else sc = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin sc = 1'b0; sc2 = 1'b0; end
            if ((sel ? adc_cs2_n : adc_cs_n) == 1'b0) cs_low++;
            if ((sel ? eoc2 : eoc) == 1'b1) begin
                lat = n;
                d   = sel ? data_out2 : data_out;
                break;
            end
        end
        nsclk = sel ? sclk_cnt2 : sclk_cnt;
        check("eoc_seen", 64'(lat > 0), 64'd1);
        @(posedge clk); #1;
        if (sel) check("eoc_fall2", {62'd0, eoc2, busy2}, 64'd0);
        else check("eoc_fall", {62'd0, eoc, busy}, 64'd0);
    endtask

    typedef struct {
        logic [31:0] sample;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_cs_low;
        int          exp_sclk;
    } vec_t;

    vec_t        vecs [5];
    int          lat, cs_low, nsclk, e0;
    logic [31:0] d;

    initial begin
        vecs[0] = '{32'hA5A5_3C3C, 32'hA5A5_3C3C, 77, 76, 32};
        vecs[1] = '{32'h0000_0000, 32'h0000_0000, 77, 76, 32};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 77, 76, 32};
        vecs[3] = '{32'h8000_0001, 32'h8000_0001, 77, 76, 32};
        vecs[4] = '{32'h1234_5678, 32'h1234_5678, 77, 76, 32};

        adc_word  = '0;
        adc_word2 = '0;
        rst  = 1'b1; rst2 = 1'b1;
        sc   = 1'b0; sc2  = 1'b0;

        // Reset holds every output at its idle value, whatever sc does.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            sc = ~sc; sc2 = ~sc2;
            check("reset_outputs", {adc_cs_n, adc_sclk, eoc, busy, ovr, 27'd0, data_out},
                  {1'b1, 4'b0, 27'd0, 32'd0});
        end
        sc = 1'b0; sc2 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; rst2 = 1'b0;
        @(posedge clk); #1;

        // Table of single conversions at default parameters.
        foreach (vecs[i]) begin
            run_conv(1'b0, vecs[i].sample, lat, d, cs_low, nsclk);
            check("vec_data", 64'(d), 64'(vecs[i].exp_data));
            check("vec_latency", 64'(lat), 64'(vecs[i].exp_lat));
            check("vec_cs_low", 64'(cs_low), 64'(vecs[i].exp_cs_low));
            check("vec_sclk", 64'(nsclk), 64'(vecs[i].exp_sclk));
        end

        // Sweep of back-to-back conversions.
        e0 = eoc_cnt;
        for (int j = 0; j < 257; j++) begin
            run_conv(1'b0, 32'hFFFF_FFFF - 32'(j), lat, d, cs_low, nsclk);
            check("sweep_data", 64'(d), 64'(32'hFFFF_FFFF - 32'(j)));
        end
        check("sweep_eoc_count", 64'(eoc_cnt - e0), 64'd257);
        check("sweep_ovr", 64'(ovr), 64'd0);

        // Overrun: a second start during SHIFT.
        adc_word = 32'hDEAD_BEEF;
        e0  = eoc_cnt;
        lat = -1;
        @(posedge clk); #1 sc = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (n == 1)  sc = 1'b0;
            if (n == 30) sc = 1'b1;
            if (n == 31) sc = 1'b0;
            if (n == 32) check("ovr_set", 64'(ovr), 64'd1);
            if (eoc) begin lat = n; d = data_out; break; end
        end
        check("ovr_latency", 64'(lat), 64'd77);
        check("ovr_data", 64'(d), 64'(32'hDEAD_BEEF));
        repeat (100) @(posedge clk);
        #1;
        check("ovr_no_extra_conv", 64'(eoc_cnt - e0), 64'd1);
        check("ovr_sticky", {62'd0, ovr, busy}, 64'b10);
        run_conv(1'b0, 32'h0F0F_0F0F, lat, d, cs_low, nsclk);
        check("ovr_cleared", 64'(ovr), 64'd0);
        check("post_ovr_data", 64'(d), 64'(32'h0F0F_0F0F));

        // Held sc gives exactly one conversion.
        adc_word = 32'h5555_AAAA;
        e0 = eoc_cnt;
        @(posedge clk); #1 sc = 1'b1;
        repeat (200) @(posedge clk);
        #1 sc = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("held_eoc_count", 64'(eoc_cnt - e0), 64'd1);
        check("held_ovr", 64'(ovr), 64'd0);
        check("held_data", 64'(data_out), 64'(32'h5555_AAAA));

        // Abort mid-SHIFT, then a fresh conversion (default instance).
        adc_word = 32'hFFFF_0000;
        sclk_cnt = 0;
        e0 = eoc_cnt;
        @(posedge clk); #1 sc = 1'b1;
        for (int n = 0; n < 200 && sclk_cnt < 10; n++) begin
            @(posedge clk); #1 sc = 1'b0;
        end
        check("abort_reached_bit10", 64'(sclk_cnt >= 10), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_async", {61'd0, adc_cs_n, adc_sclk, busy}, 64'b100);
        @(posedge clk); #1 rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("abort_no_eoc", 64'(eoc_cnt - e0), 64'd0);
        check("abort_data_kept_reset", 64'(data_out), 64'd0);
        run_conv(1'b0, 32'h0000_0001, lat, d, cs_low, nsclk);
        check("abort_fresh_data", 64'(d), 64'd1);
        check("abort_fresh_latency", 64'(lat), 64'd77);

        // Same abort sequence with SCLK_DIV=3, CONV_CYCLES=1.
        adc_word2 = 32'h7777_7777;
        sclk_cnt2 = 0;
        e0 = eoc_cnt2;
        @(posedge clk); #1 sc2 = 1'b1;
        for (int n = 0; n < 400 && sclk_cnt2 < 10; n++) begin
            @(posedge clk); #1 sc2 = 1'b0;
        end
        check("abort2_reached_bit10", 64'(sclk_cnt2 >= 10), 64'd1);
        #1 rst2 = 1'b1;
        #1;
        check("abort2_async", {61'd0, adc_cs2_n, adc_sclk2, busy2}, 64'b100);
        @(posedge clk); #1 rst2 = 1'b0;
        repeat (250) @(posedge clk);
        #1;
        check("abort2_no_eoc", 64'(eoc_cnt2 - e0), 64'd0);
        run_conv(1'b1, 32'h0000_0001, lat, d, cs_low, nsclk);
        check("div3_data", 64'(d), 64'd1);
        check("div3_latency", 64'(lat), 64'd194);
        check("div3_sclk", 64'(nsclk), 64'd32);
        run_conv(1'b1, 32'hC3A5_9611, lat, d, cs_low, nsclk);
        check("div3_data_b", 64'(d), 64'(32'hC3A5_9611));
        check("div3_cs_low", 64'(cs_low), 64'd193);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
